// File: rtl/cpu_multicycle.sv
// Multi-cycle core: FETCH/EXEC/MEM state machine with valid/ack instruction and data buses.
// Memories are external; the register bank is a separate module below, the ALU is a local function.

module cpu_regbank #(
   parameter int WORD_SIZE     = 8,
   parameter int NUM_REGISTERS = 8,
   parameter int REGISTER_BITS = $clog2(NUM_REGISTERS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_we,
   input  logic [REGISTER_BITS-1:0] i_waddr,
   input  logic [WORD_SIZE-1:0]     i_wdata,
   input  logic [REGISTER_BITS-1:0] i_raddr_a,
   input  logic [REGISTER_BITS-1:0] i_raddr_b,
   output logic [WORD_SIZE-1:0]     o_rdata_a,
   output logic [WORD_SIZE-1:0]     o_rdata_b
);
   logic [WORD_SIZE-1:0] r_regs [NUM_REGISTERS];

   // Register storage, cleared by reset, one write port.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGISTERS; i++) r_regs[i] <= '0;
      end else if (i_we) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_a = r_regs[i_raddr_a];
   assign o_rdata_b = r_regs[i_raddr_b];
endmodule

module cpu_multicycle #(
   parameter int WORD_SIZE     = 8,
   parameter int ADDR_SIZE     = 8,
   parameter int INST_SIZE     = 16,
   parameter int NUM_REGISTERS = 8,
   parameter int OPCODE_BITS   = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 imem_req,
   output logic [ADDR_SIZE-1:0] imem_addr,
   input  logic [INST_SIZE-1:0] imem_rdata,
   input  logic                 imem_ack,
   output logic                 dmem_req,
   output logic                 dmem_we,
   output logic [ADDR_SIZE-1:0] dmem_addr,
   output logic [WORD_SIZE-1:0] dmem_wdata,
   input  logic [WORD_SIZE-1:0] dmem_rdata,
   input  logic                 dmem_ack,
   output logic                 retired,
   output logic                 halted,
   output logic [2:0]           flags
);
   localparam int REGISTER_BITS = $clog2(NUM_REGISTERS);
   localparam logic [OPCODE_BITS-1:0] OP_ADD   = OPCODE_BITS'(5'd0);
   localparam logic [OPCODE_BITS-1:0] OP_ADC   = OPCODE_BITS'(5'd1);
   localparam logic [OPCODE_BITS-1:0] OP_SUB   = OPCODE_BITS'(5'd2);
   localparam logic [OPCODE_BITS-1:0] OP_AND   = OPCODE_BITS'(5'd3);
   localparam logic [OPCODE_BITS-1:0] OP_OR    = OPCODE_BITS'(5'd4);
   localparam logic [OPCODE_BITS-1:0] OP_XOR   = OPCODE_BITS'(5'd5);
   localparam logic [OPCODE_BITS-1:0] OP_INC   = OPCODE_BITS'(5'd6);
   localparam logic [OPCODE_BITS-1:0] OP_DEC   = OPCODE_BITS'(5'd7);
   localparam logic [OPCODE_BITS-1:0] OP_SHR   = OPCODE_BITS'(5'd8);
   localparam logic [OPCODE_BITS-1:0] OP_SHL   = OPCODE_BITS'(5'd9);
   localparam logic [OPCODE_BITS-1:0] OP_CMP   = OPCODE_BITS'(5'd10);
   localparam logic [OPCODE_BITS-1:0] OP_MOV   = OPCODE_BITS'(5'd11);
   localparam logic [OPCODE_BITS-1:0] OP_SET   = OPCODE_BITS'(5'd12);
   localparam logic [OPCODE_BITS-1:0] OP_JMP   = OPCODE_BITS'(5'd13);
   localparam logic [OPCODE_BITS-1:0] OP_JC    = OPCODE_BITS'(5'd14);
   localparam logic [OPCODE_BITS-1:0] OP_JZ    = OPCODE_BITS'(5'd15);
   localparam logic [OPCODE_BITS-1:0] OP_JN    = OPCODE_BITS'(5'd16);
   localparam logic [OPCODE_BITS-1:0] OP_STR   = OPCODE_BITS'(5'd17);
   localparam logic [OPCODE_BITS-1:0] OP_LOAD  = OPCODE_BITS'(5'd18);
   localparam logic [OPCODE_BITS-1:0] OP_RSTR  = OPCODE_BITS'(5'd19);
   localparam logic [OPCODE_BITS-1:0] OP_RLOAD = OPCODE_BITS'(5'd20);
   localparam logic [ADDR_SIZE-1:0]   PC_ONE   = {{(ADDR_SIZE-1){1'b0}}, 1'b1};
   localparam logic [WORD_SIZE:0]     ALU_ONE  = {{WORD_SIZE{1'b0}}, 1'b1};

   typedef enum logic [1:0] {S_FETCH = 2'd0, S_EXEC = 2'd1, S_MEM = 2'd2, S_HALT = 2'd3} state_t;

   state_t                   r_state;
   logic [ADDR_SIZE-1:0]     r_pc;
   logic [INST_SIZE-1:0]     r_ir;
   logic [2:0]               r_flags;

   logic [OPCODE_BITS-1:0]   w_opcode;
   logic [REGISTER_BITS-1:0] w_rx, w_ry;
   logic [WORD_SIZE-1:0]     w_imm, w_rx_val, w_ry_val, w_exec_wdata, w_rf_wdata;
   logic [WORD_SIZE:0]       w_alu;
   logic [2:0]               w_alu_flags;
   logic [ADDR_SIZE-1:0]     w_next_pc, w_mem_addr;
   logic [WORD_SIZE-1:0]     w_mem_wdata;
   logic                     w_valid, w_is_mem, w_is_load, w_writes, w_sets_flags;
   logic                     w_mem_we, w_rf_we;

   // Result is {carry/borrow, value}; shifts put the bit shifted out in the carry slot.
   function automatic logic [WORD_SIZE:0] alu_f(input logic [OPCODE_BITS-1:0] op,
                                                input logic [WORD_SIZE-1:0] a,
                                                input logic [WORD_SIZE-1:0] b,
                                                input logic cin);
      logic [WORD_SIZE:0] ax, bx;
      ax = {1'b0, a};
      bx = {1'b0, b};
      case (op)
         OP_ADD:         alu_f = ax + bx;
         OP_ADC:         alu_f = ax + bx + {{WORD_SIZE{1'b0}}, cin};
         OP_SUB, OP_CMP: alu_f = ax - bx;
         OP_INC:         alu_f = ax + ALU_ONE;
         OP_DEC:         alu_f = ax - ALU_ONE;
         OP_AND:         alu_f = {1'b0, a & b};
         OP_OR:          alu_f = {1'b0, a | b};
         OP_XOR:         alu_f = {1'b0, a ^ b};
         OP_SHR:         alu_f = {a[0], 1'b0, a[WORD_SIZE-1:1]};
         OP_SHL:         alu_f = {a[WORD_SIZE-1], a[WORD_SIZE-2:0], 1'b0};
         default:        alu_f = '0;
      endcase
   endfunction

   assign w_opcode = r_ir[INST_SIZE-1 -: OPCODE_BITS];
   assign w_rx     = r_ir[INST_SIZE-OPCODE_BITS-1 -: REGISTER_BITS];
   assign w_ry     = r_ir[INST_SIZE-OPCODE_BITS-REGISTER_BITS-1 -: REGISTER_BITS];
   assign w_imm    = r_ir[WORD_SIZE-1:0];

   cpu_regbank #(
      .WORD_SIZE(WORD_SIZE), .NUM_REGISTERS(NUM_REGISTERS), .REGISTER_BITS(REGISTER_BITS)
   ) u_regbank (
      .clk(clk), .rst(rst), .i_we(w_rf_we), .i_waddr(w_rx), .i_wdata(w_rf_wdata),
      .i_raddr_a(w_rx), .i_raddr_b(w_ry), .o_rdata_a(w_rx_val), .o_rdata_b(w_ry_val)
   );

   assign w_alu       = alu_f(w_opcode, w_rx_val, w_ry_val, r_flags[2]);
   assign w_alu_flags = {w_alu[WORD_SIZE], (w_alu[WORD_SIZE-1:0] == '0), w_alu[WORD_SIZE-1]};

   // Instruction decode: classify opcode, choose writeback value and next pc.
   always_comb begin
      w_valid      = 1'b1;
      w_is_mem     = 1'b0;
      w_is_load    = 1'b0;
      w_writes     = 1'b0;
      w_sets_flags = 1'b0;
      w_exec_wdata = w_alu[WORD_SIZE-1:0];
      w_next_pc    = r_pc + PC_ONE;
      case (w_opcode)
         OP_ADD, OP_ADC, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_INC, OP_DEC, OP_SHR, OP_SHL: begin
            w_writes     = 1'b1;
            w_sets_flags = 1'b1;
         end
         OP_CMP: w_sets_flags = 1'b1;
         OP_MOV: begin
            w_writes     = 1'b1;
            w_exec_wdata = w_ry_val;
         end
         OP_SET: begin
            w_writes     = 1'b1;
            w_exec_wdata = w_imm;
         end
         OP_JMP: w_next_pc = ADDR_SIZE'(w_imm);
         OP_JC:  if (r_flags[2]) w_next_pc = ADDR_SIZE'(w_imm); else w_next_pc = r_pc + PC_ONE;
         OP_JZ:  if (r_flags[1]) w_next_pc = ADDR_SIZE'(w_imm); else w_next_pc = r_pc + PC_ONE;
         OP_JN:  if (r_flags[0]) w_next_pc = ADDR_SIZE'(w_imm); else w_next_pc = r_pc + PC_ONE;
         OP_STR, OP_RSTR: w_is_mem = 1'b1;
         OP_LOAD, OP_RLOAD: begin
            w_is_mem  = 1'b1;
            w_is_load = 1'b1;
         end
         default: w_valid = 1'b0;
      endcase
   end

   assign w_mem_we    = (w_opcode == OP_STR) || (w_opcode == OP_RSTR);
   assign w_mem_addr  = (w_opcode == OP_RSTR)  ? ADDR_SIZE'(w_rx_val) :
                        (w_opcode == OP_RLOAD) ? ADDR_SIZE'(w_ry_val) : ADDR_SIZE'(w_imm);
   assign w_mem_wdata = (w_opcode == OP_RSTR) ? w_ry_val : w_rx_val;

   assign w_rf_we    = ((r_state == S_EXEC) && w_writes) ||
                       ((r_state == S_MEM) && w_is_load && dmem_ack);
   assign w_rf_wdata = (r_state == S_MEM) ? dmem_rdata : w_exec_wdata;

   // Main sequencer: fetch, execute, memory access, halt.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_FETCH;
         r_pc    <= '0;
         r_ir    <= '0;
         r_flags <= 3'b000;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (imem_ack) begin
                  r_ir    <= imem_rdata;
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (!w_valid) begin
                  r_state <= S_HALT;
               end else if (w_is_mem) begin
                  r_state <= S_MEM;
               end else begin
                  r_pc    <= w_next_pc;
                  r_state <= S_FETCH;
                  if (w_sets_flags) r_flags <= w_alu_flags;
               end
            end
            S_MEM: begin
               if (dmem_ack) begin
                  r_pc    <= r_pc + PC_ONE;
                  r_state <= S_FETCH;
               end
            end
            S_HALT:  r_state <= S_HALT;
            default: r_state <= S_HALT;
         endcase
      end
   end

   // Bus strobes are gated by rst so a reset drops them without waiting for a clock edge.
   assign imem_req   = rst && (r_state == S_FETCH);
   assign imem_addr  = r_pc;
   assign dmem_req   = rst && (r_state == S_MEM);
   assign dmem_we    = dmem_req && w_mem_we;
   assign dmem_addr  = dmem_req ? w_mem_addr : '0;
   assign dmem_wdata = dmem_req ? w_mem_wdata : '0;
   assign retired    = rst && (((r_state == S_EXEC) && w_valid && !w_is_mem) ||
                               ((r_state == S_MEM) && dmem_ack));
   assign halted     = (r_state == S_HALT);
   assign flags      = r_flags;
endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: behavioural instruction/data memories with
// programmable wait states, hand-computed expectations for each program.

module tb_cpu_multicycle;
   localparam logic [4:0] ADD = 5'd0,  ADC = 5'd1,  SHR = 5'd8,  SHL = 5'd9,  DEC = 5'd7;
   localparam logic [4:0] CMP = 5'd10, MOV = 5'd11, SET = 5'd12, JMP = 5'd13, JC  = 5'd14;
   localparam logic [4:0] JZ  = 5'd15, JN  = 5'd16, STR = 5'd17, LOAD = 5'd18;
   localparam logic [4:0] RSTR = 5'd19, RLOAD = 5'd20, BAD = 5'd31;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retired, halted;
   logic [7:0]  imem_addr, dmem_addr, dmem_wdata, dmem_rdata;
   logic [15:0] imem_rdata;
   logic [2:0]  flags;

   logic [15:0] imem [256];
   logic [7:0]  dmem [256];
   int          i_wait = 0, d_wait = 0, i_cnt = 0, d_cnt = 0, cyc = 0;
   logic        ack_force = 1'b0;
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   cpu_multicycle dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .retired(retired), .halted(halted), .flags(flags)
   );

   assign imem_rdata = imem[imem_addr];
   assign imem_ack   = ack_force || (imem_req && (i_cnt >= i_wait));
   assign dmem_rdata = dmem[dmem_addr];
   assign dmem_ack   = dmem_req && (d_cnt >= d_wait);

   // Memory model: wait-state counters, data writes, refill while reset is held.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (imem_req && !imem_ack) i_cnt <= i_cnt + 1; else i_cnt <= 0;
      if (dmem_req && !dmem_ack) d_cnt <= d_cnt + 1; else d_cnt <= 0;
      if (!rst) begin
         for (int i = 0; i < 256; i++) dmem[i] <= 8'h11;
         dmem[8'h10] <= 8'hA5;
      end else if (dmem_req && dmem_ack && dmem_we) begin
         dmem[dmem_addr] <= dmem_wdata;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] er(input logic [4:0] op, input logic [2:0] rx, input logic [2:0] ry);
      return {op, rx, ry, 5'b00000};
   endfunction

   function automatic logic [15:0] ei(input logic [4:0] op, input logic [2:0] rx, input logic [7:0] imm);
      return {op, rx, imm};
   endfunction

   task automatic clear_imem();
      for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
   endtask

   task automatic reset_cycle();
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
   endtask

   task automatic wait_retire(output int c);
      logic seen;
      seen = 1'b0;
      c = 0;
      for (int n = 0; n < 60 && !seen; n++) begin
         @(negedge clk);
         #1;
         if (retired) begin
            seen = 1'b1;
            c = cyc;
         end
      end
      check("retire_seen", 32'(seen), 32'd1);
   endtask

   int   rc [16];
   int   c, fs, rt;
   logic seen;

   initial begin
      rst = 1'b0;
      // ALU / flags / register-indirect program
      clear_imem();
      imem[0]  = ei(SET, 3'd1, 8'hFF);
      imem[1]  = ei(SET, 3'd2, 8'h01);
      imem[2]  = er(ADD, 3'd1, 3'd2);
      imem[3]  = er(ADC, 3'd3, 3'd3);
      imem[4]  = ei(STR, 3'd1, 8'h00);
      imem[5]  = ei(STR, 3'd3, 8'h01);
      imem[6]  = ei(SET, 3'd6, 8'h81);
      imem[7]  = er(SHL, 3'd6, 3'd0);
      imem[8]  = er(SHR, 3'd6, 3'd0);
      imem[9]  = er(DEC, 3'd7, 3'd0);
      imem[10] = ei(SET, 3'd4, 8'h30);
      imem[11] = er(RSTR, 3'd4, 3'd7);
      imem[12] = er(RLOAD, 3'd5, 3'd4);
      imem[13] = er(MOV, 3'd0, 3'd5);
      imem[14] = ei(STR, 3'd0, 8'h31);
      imem[15] = er(ADD, 3'd0, 3'd0);

      // Reset holds all requests low even with an ack pending
      ack_force = 1'b1;
      repeat (3) begin
         @(negedge clk);
         #1;
         check("rst_imem_req", 32'(imem_req), 32'd0);
      end
      rst = 1'b1;
      ack_force = 1'b0;
      #1;
      check("first_req", 32'(imem_req), 32'd1);
      check("first_addr", 32'(imem_addr), 32'h00);
      check("first_flags", 32'(flags), 32'd0);
      check("first_halted", 32'(halted), 32'd0);

      for (int k = 0; k < 16; k++) begin
         wait_retire(c);
         rc[k] = c;
         @(negedge clk);
         #1;
         case (k)
            2:  check("add_flags", 32'(flags), 32'b110);
            3:  check("adc_flags", 32'(flags), 32'b000);
            7:  check("shl_flags", 32'(flags), 32'b100);
            8:  check("shr_flags", 32'(flags), 32'b000);
            9:  check("dec_flags", 32'(flags), 32'b101);
            13: check("mov_keeps_flags", 32'(flags), 32'b101);
            default: ;
         endcase
      end
      check("gap_0_1", 32'(rc[1] - rc[0]), 32'd2);
      check("gap_1_2", 32'(rc[2] - rc[1]), 32'd2);
      check("gap_2_3", 32'(rc[3] - rc[2]), 32'd2);
      check("gap_str", 32'(rc[4] - rc[3]), 32'd3);
      check("r1_after_add", 32'(dmem[8'h00]), 32'h00);
      check("r3_after_adc", 32'(dmem[8'h01]), 32'h01);
      check("rstr_data", 32'(dmem[8'h30]), 32'hFF);
      check("rload_mov", 32'(dmem[8'h31]), 32'hFF);

      // Wait states on both buses
      clear_imem();
      imem[0] = ei(LOAD, 3'd4, 8'h10);
      imem[1] = ei(STR, 3'd4, 8'h11);
      i_wait = 3;
      d_wait = 2;
      reset_cycle();
      fs = cyc;
      rt = 0;
      seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
         if (imem_req && !imem_ack) check("fetch_wait_addr", 32'(imem_addr), 32'h00);
         if (dmem_req) begin
            check("load_addr", 32'(dmem_addr), 32'h10);
            check("load_we", 32'(dmem_we), 32'd0);
         end
         if (retired) begin
            seen = 1'b1;
            rt = cyc;
         end else begin
            @(negedge clk);
            #1;
         end
      end
      check("load_retired", 32'(seen), 32'd1);
      check("load_latency", 32'(rt - fs), 32'd7);
      wait_retire(c);
      @(negedge clk);
      #1;
      check("load_value", 32'(dmem[8'h11]), 32'hA5);
      i_wait = 0;
      d_wait = 0;

      // Branches and pc wrap
      clear_imem();
      imem[8'h00] = ei(SET, 3'd1, 8'h05);
      imem[8'h01] = er(CMP, 3'd1, 3'd1);
      imem[8'h02] = ei(JZ, 3'd0, 8'h20);
      imem[8'h20] = ei(JN, 3'd0, 8'h40);
      imem[8'h21] = ei(JC, 3'd0, 8'h50);
      imem[8'h22] = ei(JMP, 3'd0, 8'hFF);
      imem[8'hFF] = ei(SET, 3'd5, 8'h77);
      reset_cycle();
      for (int k = 0; k < 7; k++) begin
         wait_retire(c);
         @(negedge clk);
         #1;
         case (k)
            1: check("cmp_flags", 32'(flags), 32'b010);
            2: check("jz_taken", 32'(imem_addr), 32'h20);
            3: check("jn_not_taken", 32'(imem_addr), 32'h21);
            4: check("jc_not_taken", 32'(imem_addr), 32'h22);
            5: check("jmp_target", 32'(imem_addr), 32'hFF);
            6: check("pc_wrap", 32'(imem_addr), 32'h00);
            default: ;
         endcase
      end

      // Undefined opcode halts the core until reset
      clear_imem();
      imem[0] = ei(SET, 3'd1, 8'h01);
      imem[1] = ei(BAD, 3'd0, 8'h00);
      reset_cycle();
      wait_retire(c);
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
         @(negedge clk);
         #1;
         if (halted) seen = 1'b1;
      end
      check("halt_reached", 32'(seen), 32'd1);
      check("halt_pc", 32'(imem_addr), 32'h01);
      repeat (10) begin
         @(negedge clk);
         #1;
         check("halt_quiet", 32'({imem_req, dmem_req, retired}), 32'd0);
      end
      rst = 1'b0;
      #1;
      check("halt_cleared", 32'(halted), 32'd0);
      check("halt_rst_pc", 32'(imem_addr), 32'h00);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;

      // Reset in the middle of a stalled register store
      clear_imem();
      imem[0] = ei(SET, 3'd1, 8'h40);
      imem[1] = ei(SET, 3'd2, 8'h99);
      imem[2] = er(RSTR, 3'd1, 3'd2);
      d_wait = 1000;
      reset_cycle();
      wait_retire(c);
      wait_retire(c);
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
         @(negedge clk);
         #1;
         if (dmem_req) seen = 1'b1;
      end
      check("rstr_req", 32'(seen), 32'd1);
      check("rstr_addr", 32'(dmem_addr), 32'h40);
      #1;
      rst = 1'b0;
      #1;
      check("abort_req", 32'(dmem_req), 32'd0);
      check("abort_no_write", 32'(dmem[8'h40]), 32'h11);
      d_wait = 0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("restart_req", 32'(imem_req), 32'd1);
      check("restart_addr", 32'(imem_addr), 32'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got running expected finished");
      $fatal(1);
   end
endmodule

// File: doc/cpu_multicycle.md
Name: cpu_multicycle

Overview:
Parametrised multi-cycle successor to the single-cycle core: a FETCH/EXECUTE/MEMORY state machine with registered flags, a valid/ack handshake on separate instruction and data buses, and a HALT state on invalid opcodes. Instruction and data memories are external, so the core works with wait-state memories. Instruction set and opcode values are the ones in config.sv. Instantiates the existing registers bank; ALU function is internal.

Parameters:
WORD_SIZE, 8, datapath and register width
ADDR_SIZE, 8, instruction and data address width; pc width
INST_SIZE, 16, instruction width
NUM_REGISTERS, 8, register count; REGISTER_BITS = clog2(NUM_REGISTERS)
OPCODE_BITS, 5, opcode field width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
imem_req  out  1  instruction fetch request
imem_addr  out  ADDR_SIZE  fetch address (= pc)
imem_rdata  in  INST_SIZE  fetched instruction, valid when imem_ack=1
imem_ack  in  1  fetch complete
dmem_req  out  1  data access request
dmem_we  out  1  1 = write, 0 = read
dmem_addr  out  ADDR_SIZE  data address
dmem_wdata  out  WORD_SIZE  store data
dmem_rdata  in  WORD_SIZE  load data, valid when dmem_ack=1
dmem_ack  in  1  data access complete
retired  out  1  one-cycle pulse when an instruction completes
halted  out  1  core is in HALT
flags  out  3  {C,Z,N}, registered

Behaviour:
- Instruction fields: opcode = inst[INST_SIZE-1 -: OPCODE_BITS]; rx = next REGISTER_BITS; ry = following REGISTER_BITS; imm = inst[WORD_SIZE-1:0].
- Reset (rst=0, asynchronous): state=FETCH, pc=0, ir=0, flags=0, all registers=0. All outputs 0 while rst=0. The first fetch is requested in the first cycle after rst goes high. An asserted reset mid-transaction aborts it immediately; the pending ack is ignored.
- FETCH: imem_req=1, imem_addr=pc, held stable until imem_ack. On the edge where imem_ack=1: ir<=imem_rdata, go to EXEC. A zero-wait ack (same cycle as req) is legal.
- EXEC (1 cycle):
  - ALU ops (ADD, ADC, SUB, AND, OR, XOR, INC, DEC, SHR, SHL): rx<=result, flags updated, pc<=pc+1, retired=1, go to FETCH.
  - CMP: computes rx-ry and updates flags. No register write.
  - MOV: rx<=ry. SET: rx<=imm. Neither changes flags. pc+1, retire, go to FETCH.
  - JMP: pc<=imm. JC/JZ/JN: pc<=imm if the registered C/Z/N flag is set, else pc+1. Retire, go to FETCH.
  - STR, LOAD, RSTR, RLOAD: go to MEM; pc is not yet incremented.
  - Any other opcode: go to HALT. No retire, pc unchanged.
- MEM: dmem_req=1, held with stable addr/we/wdata until dmem_ack.
  - STR: addr=imm, wdata=rx, we=1.
  - LOAD: addr=imm, we=0.
  - RSTR: addr=rx, wdata=ry, we=1.
  - RLOAD: addr=ry, we=0.
  - On the ack edge: loads write rx<=dmem_rdata, pc<=pc+1, retired=1, go to FETCH.
- HALT: halted=1, no requests, state held until reset.
- Flag rules (arithmetic mod 2^WORD_SIZE):
  - Z: result==0. N: result MSB.
  - C for ADD/ADC/INC: carry out. ADC adds the registered C.
  - C for SUB/CMP/DEC: borrow (a<b; DEC wraps when rx==0).
  - C for SHL: old MSB. C for SHR: old LSB (logical shift, zero fill).
  - C for AND/OR/XOR: 0.
- pc wraps from 2^ADDR_SIZE-1 to 0.
- Latency: 2 cycles per non-memory instruction, 3 per memory instruction with zero-wait acks; each wait cycle adds 1.
- Register writes take effect at the retiring edge and are visible to the next instruction.

Test Plan:
- Reset and first fetch: hold rst=0 for 3 cycles with imem_ack=1 -> imem_req=0 throughout. Release -> next cycle imem_req=1, imem_addr=0, flags=0.
- ALU, flags, ADC: SET r1,0xFF; SET r2,0x01; ADD r1,r2; ADC r3,r3 with r3=0 -> r1=0x00, flags C=1 Z=1 N=0; r3=0x01, flags cleared. Four retired pulses, each 2 cycles apart.
- Wait states: imem_ack delayed 3 cycles, then LOAD r4,0x10 with dmem_ack delayed 2 and dmem_rdata=0xA5 -> imem_addr and dmem_addr stable while waiting; dmem_we=0; r4=0xA5; retire 7 cycles after fetch start.
- Branches and wrap: CMP r1,r1 then JZ 0x20 -> pc=0x20. JN 0x40 with N=0 -> pc=0x21. With pc=0xFF and a non-jump instruction -> next fetch at 0x00.
- Halt: fetch an undefined opcode -> halted=1 after EXEC, no imem_req/dmem_req for 10 cycles, retired=0. Pulse rst -> pc=0, halted=0.
- Reset mid-transaction: assert rst during a RSTR with dmem_req=1 and no ack -> dmem_req drops with no clock edge, memory is not written. After release, fetch restarts at 0.
